// File: rtl/he_lb_err_ctrl.sv
// he_lb_err_ctrl: host-exerciser loopback error-injection controller.
//
// A CSR write arms a set of protocol-checker error bits. The controller waits
// for a packet boundary on the TX stream, then drives the error-select vector
// to the injector for one packet (one-shot) or until aborted (continuous).
// Packets corrupted while injecting are counted.
//
// Build option: define HE_LB_ERR_CNT_EN to build the saturating
// injected-packet counter; without it inj_count is tied to zero.
//
// Handshake: the TX taps are monitor-only. A beat transfers when
// tx_tvalid & tx_tready are both high on a rising clk edge; tx_tlast is
// meaningful only on such a beat. The controller never drives tx_tready.
//
// dbg_state exposes the FSM state: 0 IDLE, 1 ARMED, 2 ACTIVE, 3 DRAIN.

package he_lb_err_pkg;

  typedef struct packed {
    logic tx_req_counter_oflow;
    logic malformed_tlp;
    logic max_payload;
    logic max_read_req_size;
    logic max_tag;
    logic unexp_mmio_rsp;
    logic mmio_timeout;
    logic mmio_wr_while_rst;
    logic mmio_insufficient_data;
    logic mmio_data_payload_overrun;
    logic tx_mwr_insufficient_data;
    logic tx_mwr_data_payload_overrun;
  } t_prtcl_chkr_err_vector;

endpackage

module he_lb_err_ctrl
  import he_lb_err_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   SoftReset,
  input  logic                   csr_wr,
  input  t_prtcl_chkr_err_vector csr_wdata,
  input  logic                   csr_mode,
  input  logic                   csr_abort,
  input  logic                   tx_tvalid,
  input  logic                   tx_tready,
  input  logic                   tx_tlast,
  output t_prtcl_chkr_err_vector error_inj,
  output logic                   inj_busy,
  output logic                   inj_done,
  output logic [CNT_W-1:0]       inj_count,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_ACTIVE = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  t_prtcl_chkr_err_vector pend;
  t_prtcl_chkr_err_vector pend_nxt;
  logic                   mode;
  logic                   mode_nxt;
  logic                   in_pkt;
  logic                   done_nxt;
  logic                   cnt_evt;
  logic                   hs;
  logic                   eop;
  logic                   inject_nxt;

  assign hs  = tx_tvalid & tx_tready;
  assign eop = hs & tx_tlast;

  // Track whether the monitored stream is between SOP and EOP.
  always_ff @(posedge clk) begin
    if (SoftReset) begin
      in_pkt <= 1'b0;
    end else if (hs) begin
      in_pkt <= ~tx_tlast;
    end
  end

  // State, latched request and registered outputs.
  always_ff @(posedge clk) begin
    if (SoftReset) begin
      state     <= S_IDLE;
      pend      <= '0;
      mode      <= 1'b0;
      error_inj <= '0;
      inj_done  <= 1'b0;
    end else begin
      state     <= state_nxt;
      pend      <= pend_nxt;
      mode      <= mode_nxt;
      error_inj <= inject_nxt ? pend_nxt : '0;
      inj_done  <= done_nxt;
    end
  end

  // Next-state logic: arming, boundary wait, completion, abort and drain.
  always_comb begin
    state_nxt = state;
    pend_nxt  = pend;
    mode_nxt  = mode;
    done_nxt  = 1'b0;
    cnt_evt   = 1'b0;
    case (state)
      S_IDLE: begin
        // Abort in the same cycle drops the write; an all-zero request
        // would inject nothing, so it is treated as a no-op.
        if (csr_wr && !csr_abort && (csr_wdata != '0)) begin
          pend_nxt  = csr_wdata;
          mode_nxt  = csr_mode;
          state_nxt = S_ARMED;
        end
      end
      S_ARMED: begin
        // Only enter ACTIVE in a quiet cycle between packets so that the
        // first corrupted beat is always a SOP. No timeout here.
        if (csr_abort) begin
          state_nxt = S_IDLE;
        end else if (!in_pkt && !hs) begin
          state_nxt = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        // The first EOP seen in ACTIVE ends the victim packet, because
        // ACTIVE is only entered at a packet boundary.
        cnt_evt = eop;
        if (!mode && eop) begin
          // One-shot completion beats a coincident abort.
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
        end else if (csr_abort) begin
          state_nxt = (!in_pkt && !hs) ? S_IDLE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Keep corrupting until the packet in flight finishes.
        if (eop) begin
          cnt_evt   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    inject_nxt = (state_nxt == S_ACTIVE) || (state_nxt == S_DRAIN);
  end

  assign inj_busy  = (state != S_IDLE);
  assign dbg_state = state;

`ifdef HE_LB_ERR_CNT_EN
  logic [CNT_W-1:0] cnt;

  // Saturating count of corrupted packets.
  always_ff @(posedge clk) begin
    if (SoftReset) begin
      cnt <= '0;
    end else if (cnt_evt && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign inj_count = cnt;
`else
  logic unused_cnt_evt;

  assign unused_cnt_evt = cnt_evt;
  assign inj_count      = '0;
`endif

endmodule

// File: tb/tb_he_lb_err_ctrl.sv
// Testbench for he_lb_err_ctrl: a table of one-shot vectors, directed
// sequences for the multi-cycle corners and a randomized run, all checked
// against a transaction-level reference model.
module tb_he_lb_err_ctrl;
  import he_lb_err_pkg::*;

  localparam int W       = $bits(t_prtcl_chkr_err_vector);
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst;
  logic                   wr;
  t_prtcl_chkr_err_vector wdata;
  logic                   md;
  logic                   ab;
  logic                   tv;
  logic                   tr;
  logic                   tl;
  t_prtcl_chkr_err_vector err_inj;
  logic                   busy;
  logic                   done;
  logic [CNT_W-1:0]       count;
  logic [1:0]             dbg_state;

  he_lb_err_ctrl #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .SoftReset (rst),
    .csr_wr    (wr),
    .csr_wdata (wdata),
    .csr_mode  (md),
    .csr_abort (ab),
    .tx_tvalid (tv),
    .tx_tready (tr),
    .tx_tlast  (tl),
    .error_inj (err_inj),
    .inj_busy  (busy),
    .inj_done  (done),
    .inj_count (count),
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phases: 0 idle, 1 waiting for a boundary, 2 corrupting, 3 finishing
  // the aborted packet.
  int           m_phase;
  logic [W-1:0] m_pend;
  logic         m_cont;
  logic         m_mid;
  logic         m_done;
  int           m_count;

  function automatic int exp_count();
`ifdef HE_LB_ERR_CNT_EN
    return m_count;
`else
    return 0;
`endif
  endfunction

  task automatic model_edge(input logic r, input logic w, input logic [W-1:0] d,
                            input logic cm, input logic a, input logic v,
                            input logic rd, input logic la);
    bit xfer;
    bit last;
    bit counted;
    xfer    = v && rd;
    last    = xfer && la;
    counted = 0;
    m_done  = 0;
    if (r) begin
      m_phase = 0; m_pend = '0; m_cont = 0; m_mid = 0; m_count = 0;
      return;
    end
    if (m_phase == 0) begin
      if (w && !a && d != 0) begin
        m_pend = d; m_cont = cm; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (a) m_phase = 0;
      else if (!m_mid && !xfer) m_phase = 2;
    end else if (m_phase == 2) begin
      if (last) counted = 1;
      if (last && !m_cont) begin
        m_phase = 0; m_done = 1;
      end else if (a) begin
        m_phase = (!m_mid && !xfer) ? 0 : 3;
      end
    end else begin
      if (last) begin
        counted = 1; m_phase = 0;
      end
    end
    if (counted && m_count < CNT_MAX) m_count++;
    if (xfer) m_mid = !la;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic r, input logic w, input logic [W-1:0] d,
                      input logic cm, input logic a, input logic v,
                      input logic rd, input logic la);
    rst = r; wr = w; wdata = d; md = cm; ab = a; tv = v; tr = rd; tl = la;
    @(posedge clk);
    model_edge(r, w, d, cm, a, v, rd, la);
    #1;
    chk("error_inj", {20'd0, err_inj}, {20'd0, (m_phase >= 2) ? m_pend : {W{1'b0}}});
    chk("inj_busy", {31'd0, busy}, {31'd0, (m_phase != 0)});
    chk("inj_done", {31'd0, done}, {31'd0, m_done});
    chk("inj_count", {28'd0, count}, 32'(exp_count()));
    chk("state", {30'd0, dbg_state}, 32'(m_phase));
  endtask

  task automatic do_reset();
    step(1, 0, '0, 0, 0, 0, 0, 0);
  endtask
  task automatic idle();
    step(0, 0, '0, 0, 0, 0, 0, 0);
  endtask
  task automatic beat(input logic la);
    step(0, 0, '0, 0, 0, 1, 1, la);
  endtask
  task automatic arm(input logic [W-1:0] d, input logic cm);
    step(0, 1, d, cm, 0, 0, 0, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic         r;
    logic         w;
    logic [W-1:0] d;
    logic         cm;
    logic         v;
    logic         la;
    logic         e_err;
    logic         e_busy;
    logic         e_done;
    int           e_cnt;
  } vec_t;

  function automatic vec_t mk(logic r, logic w, logic [W-1:0] d, logic cm, logic v,
                              logic la, logic e_err, logic e_busy, logic e_done, int e_cnt);
    vec_t x;
    x.r = r; x.w = w; x.d = d; x.cm = cm; x.v = v; x.la = la;
    x.e_err = e_err; x.e_busy = e_busy; x.e_done = e_done; x.e_cnt = e_cnt;
    return x;
  endfunction

  vec_t tbl[10];

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    t_prtcl_chkr_err_vector mt;
    logic [W-1:0] d;
    int done_seen;
    int cnt_before;

    mt = '0;
    mt.max_tag = 1'b1;

    // One-shot max_tag: arm, two quiet cycles, 3-beat victim, then a clean packet.
    tbl[0] = mk(1, 0, '0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1] = mk(0, 1, mt, 0, 0, 0, 0, 1, 0, 0);
    tbl[2] = mk(0, 0, '0, 0, 0, 0, 1, 1, 0, 0);
    tbl[3] = mk(0, 0, '0, 0, 0, 0, 1, 1, 0, 0);
    tbl[4] = mk(0, 0, '0, 0, 1, 0, 1, 1, 0, 0);
    tbl[5] = mk(0, 0, '0, 0, 1, 0, 1, 1, 0, 0);
    tbl[6] = mk(0, 0, '0, 0, 1, 1, 0, 0, 1, 1);
    tbl[7] = mk(0, 0, '0, 0, 0, 0, 0, 0, 0, 1);
    tbl[8] = mk(0, 0, '0, 0, 1, 0, 0, 0, 0, 1);
    tbl[9] = mk(0, 0, '0, 0, 1, 1, 0, 0, 0, 1);

    rst = 1; wr = 0; wdata = '0; md = 0; ab = 0; tv = 0; tr = 0; tl = 0;
    m_phase = 0; m_pend = '0; m_cont = 0; m_mid = 0; m_done = 0; m_count = 0;

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].r, tbl[i].w, tbl[i].d, tbl[i].cm, 0, tbl[i].v, tbl[i].v, tbl[i].la);
      chk($sformatf("tbl%0d_err", i), {20'd0, err_inj}, {20'd0, tbl[i].e_err ? mt : {W{1'b0}}});
      chk($sformatf("tbl%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].e_busy});
      chk($sformatf("tbl%0d_done", i), {31'd0, done}, {31'd0, tbl[i].e_done});
`ifdef HE_LB_ERR_CNT_EN
      chk($sformatf("tbl%0d_cnt", i), {28'd0, count}, 32'(tbl[i].e_cnt));
`else
      chk($sformatf("tbl%0d_cnt", i), {28'd0, count}, 32'd0);
`endif
    end

    // Arming mid-packet: the packet in flight stays clean, the next is the victim.
    do_reset();
    d = 12'h0a5;
    beat(0);
    step(0, 1, d, 0, 0, 1, 1, 0);
    beat(0);
    chk("mid_arm_err", {20'd0, err_inj}, 32'd0);
    beat(1);
    chk("mid_arm_still_armed", {30'd0, dbg_state}, 32'd1);
    idle();
    chk("mid_arm_active_err", {20'd0, err_inj}, {20'd0, d});
    beat(0);
    beat(1);
    chk("mid_arm_done", {31'd0, done}, 32'd1);

    // Continuous over 5 packets, abort on beat 2 of packet 6.
    do_reset();
    d = 12'h301;
    done_seen = 0;
    arm(d, 1);
    idle();
    for (int p = 0; p < 5; p++) begin
      beat(0); beat(0); beat(1);
      done_seen += done;
      chk("cont_err_held", {20'd0, err_inj}, {20'd0, d});
    end
    beat(0);
    step(0, 0, '0, 0, 1, 1, 1, 0);
    chk("cont_drain", {30'd0, dbg_state}, 32'd3);
    beat(0);
    chk("drain_err_held", {20'd0, err_inj}, {20'd0, d});
    beat(1);
    done_seen += done;
    chk("drain_idle", {31'd0, busy}, 32'd0);
`ifdef HE_LB_ERR_CNT_EN
    chk("cont_count6", {28'd0, count}, 32'd6);
`else
    chk("cont_count6", {28'd0, count}, 32'd0);
`endif
    chk("cont_no_done", 32'(done_seen), 32'd0);

    // Abort and write together while armed: abort wins.
    do_reset();
    arm(12'h010, 0);
    step(0, 1, 12'h7ff, 1, 1, 0, 0, 0);
    chk("abort_wr_idle", {31'd0, busy}, 32'd0);
    idle();
    chk("abort_wr_no_inj", {20'd0, err_inj}, 32'd0);

    // One-shot tlast coinciding with abort counts as completion.
    arm(12'h010, 0);
    idle();
    cnt_before = exp_count();
    beat(0);
    step(0, 0, '0, 0, 1, 1, 1, 1);
    chk("eop_abort_done", {31'd0, done}, 32'd1);
    chk("eop_abort_idle", {31'd0, busy}, 32'd0);
`ifdef HE_LB_ERR_CNT_EN
    chk("eop_abort_cnt", {28'd0, count}, 32'(cnt_before + 1));
`else
    chk("eop_abort_cnt", {28'd0, count}, 32'(cnt_before));
`endif

    // Reset on beat 2 of the victim packet.
    arm(12'h444, 0);
    idle();
    beat(0);
    step(1, 0, '0, 0, 0, 1, 1, 0);
    chk("rst_err", {20'd0, err_inj}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cnt", {28'd0, count}, 32'd0);
    done_seen = 0;
    beat(0); done_seen += done;
    beat(1); done_seen += done;
    idle();  done_seen += done;
    chk("rst_no_done", 32'(done_seen), 32'd0);

    // Saturation: 20 single-beat packets in continuous mode.
    do_reset();
    arm(12'h800, 1);
    idle();
    for (int p = 0; p < 20; p++) beat(1);
`ifdef HE_LB_ERR_CNT_EN
    chk("sat_count", {28'd0, count}, 32'(CNT_MAX));
`else
    chk("sat_count", {28'd0, count}, 32'd0);
`endif

    // Randomized traffic and CSR activity against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic r, w, cm, a, v, rd, la;
      r  = ($urandom_range(0, 299) == 0);
      w  = ($urandom_range(0, 19) == 0);
      d  = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom_range(1, (1 << W) - 1));
      cm = $urandom_range(0, 1) == 1;
      a  = ($urandom_range(0, 39) == 0);
      v  = ($urandom_range(0, 9) < 7);
      rd = ($urandom_range(0, 9) < 7);
      la = ($urandom_range(0, 9) < 3);
      step(r, w, d, cm, a, v, rd, la);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
